// File: rtl/recv_data_arbiter.sv
// Round-robin arbiter that shares the Nios recv_data input PIO among NUM_REQ producers.
// Holds each tagged word with a strobe until a software ack toggle or a timeout, then forces a strobe-low gap.
module recv_data_arbiter #(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned TIMEOUT    = 1024,
  parameter  int unsigned GAP_CYCLES = 2,
  localparam int unsigned SRC_W      = $clog2(NUM_REQ),
  localparam int unsigned PAYLOAD_W  = 31 - SRC_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           ack_toggle,
  input  logic                           err_clear,
  output logic [31:0]                    pio_word,
  output logic                           busy,
  output logic                           err_timeout,
  output logic [7:0]                     drop_count,
  output logic [SRC_W-1:0]               last_grant
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 ack_q;
  logic [TO_W-1:0]      to_cnt;
  logic [GAP_W-1:0]     gap_cnt;

  logic                 grant_hit;
  logic [SRC_W-1:0]     grant_idx;
  logic [SRC_W-1:0]     cand;
  logic [PAYLOAD_W-1:0] grant_payload;
  logic                 grant_fire;
  logic                 ack_evt;
  logic                 timeout_evt;
  logic                 gap_done;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((32'(last_grant) + k) % NUM_REQ);
      if (!grant_hit && req_valid[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_payload = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) grant_payload = req_data[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  assign grant_fire  = (state_q == IDLE) && en && grant_hit;
  assign ack_evt     = (ack_toggle != ack_q);
  // An ack on the terminal count wins over the timeout.
  assign timeout_evt = (state_q == PRESENT) && !ack_evt && (to_cnt == TO_W'(TIMEOUT - 1));
  assign gap_done    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_fire)              state_d = PRESENT;
      PRESENT: if (ack_evt || timeout_evt)  state_d = GAP;
      GAP:     if (gap_done)                state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant_fire && reset_n) req_ready[grant_idx] = 1'b1;
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_word    <= '0;
      ack_q       <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      last_grant  <= SRC_W'(NUM_REQ - 1);
      err_timeout <= 1'b0;
      drop_count  <= '0;
    end else begin
      ack_q <= ack_toggle;
      case (state_q)
        IDLE: begin
          if (grant_fire) begin
            pio_word   <= {1'b1, grant_idx, grant_payload};
            last_grant <= grant_idx;
            to_cnt     <= '0;
          end
        end
        PRESENT: begin
          if (ack_evt || timeout_evt) begin
            pio_word[31] <= 1'b0;
            gap_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase

      if (timeout_evt)    err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;

      if (timeout_evt && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: doc/recv_data_arbiter.md
# recv_data_arbiter

Round-robin arbiter and handshake sequencer that shares the Nios `recv_data` 32-bit input PIO among several hardware producers (e.g. processing-node receive channels). It grants one requester at a time and latches the winner's payload, tagged with its source ID, onto the PIO input word. It raises a strobe bit so the PIO edge-capture logic flags the word, then holds the word until the Nios software acknowledges it through a toggle bit on an output PIO. Missing acknowledges time out and are counted.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `SRC_W`, localparam = clog2(NUM_REQ): width of the source-ID field.
- `PAYLOAD_W`, localparam = 31 - SRC_W: payload bits per requester (29 at the default).
- `TIMEOUT`, 1024: cycles to wait for an acknowledge, ≥2.
- `GAP_CYCLES`, 2: cycles the strobe is held low between words, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  when 0, no new grants are issued; an in-flight word completes normally.
- `req_valid`  in  NUM_REQ  per-requester word-available flag.
- `req_data`  in  NUM_REQ*PAYLOAD_W  packed payloads; requester i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- `req_ready`  out  NUM_REQ  one-hot grant; a word transfers when valid & ready are both high at a clock edge.
- `ack_toggle`  in  1  from a Nios output PIO; each level change acknowledges the current word.
- `err_clear`  in  1  clears `err_timeout`.
- `pio_word`  out  32  drives `recv_data` in_port; layout {strobe[31], src_id[30 -: SRC_W], payload[PAYLOAD_W-1:0]}.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `err_timeout`  out  1  sticky flag; set on any timeout.
- `drop_count`  out  8  saturating count of timed-out words.
- `last_grant`  out  SRC_W  index of the most recent winner.

## Operation
- FSM states: IDLE, PRESENT, GAP.
- IDLE:
  - If `en` is high and any `req_valid` is high, pick the winner by round-robin. The search starts at (last_grant+1) mod NUM_REQ.
  - `req_ready` is combinational and high only for the winner, in this cycle.
  - On the clock edge: latch the winner's payload and ID into `pio_word`, set strobe = 1, update `last_grant`, clear the timeout counter, and go to PRESENT.
- PRESENT:
  - `pio_word` is held stable.
  - An acknowledge event is `ack_toggle` != `ack_q`, where `ack_q` is a register that samples `ack_toggle` every cycle in every state.
  - On an acknowledge event: strobe ← 0, go to GAP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1: strobe ← 0, `err_timeout` ← 1, `drop_count` increments (saturates at 255), go to GAP.
- GAP:
  - strobe stays 0; payload and ID bits are held.
  - The gap counter counts GAP_CYCLES cycles, then the FSM returns to IDLE. This guarantees that the PIO's two-stage rising-edge detector sees a low between words.
- Acknowledge events outside PRESENT are ignored; `ack_q` still tracks the input.
- `req_ready` is all-zero in PRESENT and GAP.
- Simultaneous-event priorities:
  - An acknowledge in the same cycle as the timeout terminal count is treated as an acknowledge; no error is raised.
  - `err_clear` in the same cycle as a timeout leaves `err_timeout` set.
- Deasserting `en` mid-transaction does not abort the transaction.

## Timing
- Reset values: `pio_word` = 0, FSM = IDLE, `ack_q` = 0, `last_grant` = NUM_REQ-1 (so requester 0 has first priority), `err_timeout` = 0, `drop_count` = 0, `busy` = 0.
- `req_ready` = 0 during reset and whenever the FSM is not in IDLE.
- Grant latency:
  - `req_valid` sampled high in IDLE at cycle t gives `req_ready` high at t.
  - `pio_word` is valid with strobe = 1 from t+1.
  - The PIO edge-capture bit 31 sets at t+3 (two flops plus capture).
- Acknowledge latency:
  - A toggle first visible at cycle u gives strobe = 0 at u+1.
  - The FSM is back in IDLE at u+1+GAP_CYCLES, where the next grant is possible.
- Timeout: with no acknowledge, strobe falls exactly TIMEOUT cycles after it rose.
- Reset asserted mid-operation returns all state to reset values immediately; `pio_word` reads 0.

## Test plan
- **Single word.** After reset, req_valid = 0b0001 with payload 0x0ABCDEF, then toggle ack 10 cycles after the strobe rises. Required: `pio_word` = 0x80ABCDEF, one `req_ready[0]` pulse, strobe low for exactly 2 cycles, then IDLE.
- **Round-robin fairness.** req_valid = 0b1111 held, with an ack for every word. Required: grant order 0,1,2,3,0; src_id fields 0,1,2,3,0.
- **Timeout.** TIMEOUT = 16, one requester, no ack. Required: strobe high for exactly 16 cycles, `err_timeout` = 1, `drop_count` = 1. After 300 repeats, `drop_count` = 255 (saturated).
- **Simultaneous events.** An ack toggle on the timeout terminal cycle → no error. `err_clear` on a timeout cycle → `err_timeout` stays 1.
- **Enable and stray ack.** Drop `en` during PRESENT → the word completes, then no further grants while `en` = 0. An ack toggle during IDLE/GAP → no state change.
- **Reset mid-PRESENT.** Assert reset_n low → `pio_word` = 0, `req_ready` = 0. After release, requester 0 has first priority.
